// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch mode controller and its BCD counters.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [7:0]  SEC_MAX = 8'h59;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;

  // Decimal 0..99 to packed two-digit BCD.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
    tens = DIGIT_W'((v / 10) % 10);
    ones = DIGIT_W'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd2_counter.sv
// Two-digit BCD counter with a wrap value; clear beats increment.
module bcd2_counter
  import stopwatch_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0]         value_nxt;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;

  assign tens = value[7:4];
  assign ones = value[3:0];
  assign wrap = inc && (value == MAX);

  always_comb begin
    value_nxt = value;
    if (clr) begin
      value_nxt = '0;
    end else if (inc) begin
      if (value == MAX)
        value_nxt = '0;
      else if (ones >= DIGIT_W'(9))
        value_nxt = {tens + DIGIT_W'(1), DIGIT_W'(0)};
      else
        value_nxt = {tens, ones + DIGIT_W'(1)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      value <= '0;
    else
      value <= value_nxt;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM (run/pause/adjust), minutes:seconds BCD time base and blink control.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_pls,
  input  logic       clear_pls,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       blank_min,
  output logic       blank_sec,
  output logic [1:0] state
);

  state_t cur;
  state_t nxt;
  logic   phase;
  logic   phase_nxt;
  logic   sec_inc;
  logic   min_inc;
  logic   sec_wrap;
  logic   min_wrap_unused;

  // Counting is decided from the state before the edge, so a mode request
  // and a tick in the same cycle see the old mode.
  assign sec_inc = (cur == ST_RUN && tick_1hz) || (cur == ST_ADJ && sel && tick_2hz);
  assign min_inc = (cur == ST_RUN && sec_wrap) || (cur == ST_ADJ && !sel && tick_2hz);

  bcd2_counter #(
    .MAX(SEC_MAX)
  ) u_sec (
    .clk  (clk),
    .rst  (rst),
    .inc  (sec_inc),
    .clr  (clear_pls),
    .value(seconds),
    .wrap (sec_wrap)
  );

  bcd2_counter #(
    .MAX(to_bcd(MAX_MIN))
  ) u_min (
    .clk  (clk),
    .rst  (rst),
    .inc  (min_inc),
    .clr  (clear_pls),
    .value(minutes),
    .wrap (min_wrap_unused)
  );

  always_comb begin
    nxt = cur;
    if (adj)
      nxt = ST_ADJ;
    else if (cur == ST_ADJ)
      nxt = ST_PAUSE;
    else if (cur == ST_RUN && pause_pls)
      nxt = ST_PAUSE;
    else if (cur == ST_PAUSE && pause_pls)
      nxt = ST_RUN;
  end

  always_comb begin
    phase_nxt = phase;
    if (clear_pls || (cur != ST_ADJ && nxt == ST_ADJ))
      phase_nxt = 1'b0;
    else if (cur == ST_ADJ && tick_2hz)
      phase_nxt = !phase;
  end

  // Blank outputs are registered from the post-edge mode/phase and the sampled sel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur       <= ST_RUN;
      phase     <= 1'b0;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      cur       <= nxt;
      phase     <= phase_nxt;
      blank_min <= (nxt == ST_ADJ) && !sel && phase_nxt;
      blank_sec <= (nxt == ST_ADJ) && sel && phase_nxt;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: two instances (MAX_MIN 59 and 99) against an integer reference model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick_1hz, tick_2hz, pause_pls, clear_pls, adj, sel;
  logic [7:0] min_a, sec_a, min_b, sec_b;
  logic       bm_a, bs_a, bm_b, bs_b;
  logic [1:0] st_a, st_b;

  stopwatch_ctrl #(.MAX_MIN(59)) u_dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_pls(pause_pls), .clear_pls(clear_pls), .adj(adj), .sel(sel),
    .minutes(min_a), .seconds(sec_a), .blank_min(bm_a), .blank_sec(bs_a), .state(st_a)
  );

  stopwatch_ctrl #(.MAX_MIN(99)) u_dut99 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_pls(pause_pls), .clear_pls(clear_pls), .adj(adj), .sel(sel),
    .minutes(min_b), .seconds(sec_b), .blank_min(bm_b), .blank_sec(bs_b), .state(st_b)
  );

  typedef struct {
    logic [7:0] mn0;
    logic [7:0] mn1;
    logic [7:0] sec;
    logic       bm;
    logic       bs;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: plain integers, modes 0=run 1=pause 2=adjust.
  int   m_st = 0;
  int   m_sec = 0;
  int   m_mn[2] = '{0, 0};
  int   m_max[2] = '{59, 99};
  int   m_phase = 0;
  logic a_lvl = 1'b0;
  logic s_lvl = 1'b0;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic bit legal(input logic [7:0] v, input logic [7:0] mx);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= mx);
  endfunction

  task automatic model_step(input logic r, t1, t2, p, c, a, s);
    int   cur;
    int   nst;
    exp_t e;
    if (!r) begin
      m_st = 0; m_sec = 0; m_mn[0] = 0; m_mn[1] = 0; m_phase = 0;
    end else begin
      cur = m_st;
      if (c) begin
        m_sec = 0; m_mn[0] = 0; m_mn[1] = 0;
      end else if (cur == 0 && t1) begin
        m_sec = m_sec + 1;
        if (m_sec == 60) begin
          m_sec = 0;
          for (int k = 0; k < 2; k++) m_mn[k] = (m_mn[k] == m_max[k]) ? 0 : m_mn[k] + 1;
        end
      end else if (cur == 2 && t2) begin
        if (s) m_sec = (m_sec + 1) % 60;
        else for (int k = 0; k < 2; k++) m_mn[k] = (m_mn[k] + 1) % (m_max[k] + 1);
      end
      if (a) nst = 2;
      else if (cur == 2) nst = 1;
      else if (p) nst = (cur == 0) ? 1 : 0;
      else nst = cur;
      if (c || (cur != 2 && nst == 2)) m_phase = 0;
      else if (cur == 2 && t2) m_phase = 1 - m_phase;
      m_st = nst;
    end
    e.mn0 = bcd(m_mn[0]);
    e.mn1 = bcd(m_mn[1]);
    e.sec = bcd(m_sec);
    e.bm  = (m_st == 2) && !s && (m_phase == 1);
    e.bs  = (m_st == 2) && s && (m_phase == 1);
    e.st  = 2'(m_st);
    exp_q.push_back(e);
  endtask

  // One clock: drive at negedge, record expectation, return just after the edge.
  task automatic cyc(input logic r, t1, t2, p, c, a, s);
    @(negedge clk);
    rst = r; tick_1hz = t1; tick_2hz = t2; pause_pls = p; clear_pls = c; adj = a; sel = s;
    model_step(r, t1, t2, p, c, a, s);
    @(posedge clk);
    #2;
  endtask

  task automatic tk(input logic t1, t2, p, c);
    cyc(1'b1, t1, t2, p, c, a_lvl, s_lvl);
  endtask

  task automatic tkn(input int n, input logic t1, t2);
    for (int i = 0; i < n; i++) tk(t1, t2, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every post-reset edge presents a new output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if ({min_a, sec_a, bm_a, bs_a, st_a} !== {e.mn0, e.sec, e.bm, e.bs, e.st}) begin
          bad++;
          $display("FAIL sb_max59 got=%h:%h bm=%b bs=%b st=%0d want=%h:%h bm=%b bs=%b st=%0d",
                   min_a, sec_a, bm_a, bs_a, st_a, e.mn0, e.sec, e.bm, e.bs, e.st);
        end
        total++;
        if ({min_b, sec_b, bm_b, bs_b, st_b} !== {e.mn1, e.sec, e.bm, e.bs, e.st}) begin
          bad++;
          $display("FAIL sb_max99 got=%h:%h bm=%b bs=%b st=%0d want=%h:%h bm=%b bs=%b st=%0d",
                   min_b, sec_b, bm_b, bs_b, st_b, e.mn1, e.sec, e.bm, e.bs, e.st);
        end
        total++;
        if (!(legal(sec_a, 8'h59) && legal(min_a, 8'h59) && legal(sec_b, 8'h59) && legal(min_b, 8'h99))) begin
          bad++;
          $display("FAIL bcd_range got=%h:%h %h:%h want legal BCD within limits", min_a, sec_a, min_b, sec_b);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0; pause_pls = 1'b0;
    clear_pls = 1'b0; adj = 1'b0; sel = 1'b0;

    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_time", {min_a, sec_a, min_b, sec_b}, 32'h0);
    chk("rst_state", {st_a, st_b, bm_a, bs_a, bm_b, bs_b}, 32'h0);

    tkn(61, 1'b1, 1'b0);
    chk("count_61", {min_a, sec_a, min_b, sec_b}, 32'h0101_0101);

    tk(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pause_state", {30'd0, st_a}, 32'd1);
    tkn(5, 1'b1, 1'b0);
    chk("pause_hold", {min_a, sec_a}, 32'h0101);
    tk(1'b0, 1'b0, 1'b1, 1'b0);
    chk("resume_state", {30'd0, st_a}, 32'd0);
    tk(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_count", {min_a, sec_a}, 32'h0102);
    tk(1'b1, 1'b0, 1'b1, 1'b0);
    chk("tick_pause", {min_a, sec_a, 6'd0, st_a}, {16'h0103, 8'd1});
    tk(1'b0, 1'b0, 1'b1, 1'b0);

    tk(1'b0, 1'b0, 1'b0, 1'b1);
    a_lvl = 1'b1; s_lvl = 1'b0;
    tk(1'b0, 1'b1, 1'b0, 1'b0);
    chk("adj_enter_no_inc", {min_a, sec_a, 6'd0, st_a}, {16'h0000, 8'd2});
    tkn(12, 1'b0, 1'b1);
    s_lvl = 1'b1;
    tkn(34, 1'b0, 1'b1);
    chk("adj_1234", {min_a, sec_a}, 32'h1234);
    a_lvl = 1'b0;
    tkn(1, 1'b0, 1'b0);
    chk("adj_exit", {st_a, bm_a, bs_a}, {28'd0, 2'd1, 2'b00});
    tk(1'b0, 1'b0, 1'b1, 1'b0);
    tk(1'b1, 1'b0, 1'b0, 1'b1);
    chk("clear_vs_tick", {min_a, sec_a, 6'd0, st_a}, {16'h0000, 8'd0});

    tkn(9, 1'b1, 1'b0);
    chk("digit_09", {24'd0, sec_a}, 32'h09);
    tk(1'b1, 1'b0, 1'b0, 1'b0);
    chk("digit_10", {24'd0, sec_a}, 32'h10);

    tk(1'b0, 1'b0, 1'b0, 1'b1);
    tkn(58, 1'b1, 1'b0);
    a_lvl = 1'b1; s_lvl = 1'b1;
    tkn(1, 1'b0, 1'b0);
    chk("blink_enter", {st_a, bm_a, bs_a}, {28'd0, 2'd2, 2'b00});
    tk(1'b0, 1'b1, 1'b0, 1'b0);
    chk("blink_1", {sec_a, bm_a, bs_a}, {22'd0, 8'h59, 2'b01});
    tk(1'b0, 1'b1, 1'b0, 1'b0);
    chk("blink_2", {min_a, sec_a, bm_a, bs_a}, {14'd0, 16'h0000, 2'b00});
    tk(1'b0, 1'b1, 1'b0, 1'b0);
    chk("blink_3", {min_a, sec_a, bm_a, bs_a}, {14'd0, 16'h0001, 2'b01});
    a_lvl = 1'b0;
    tkn(1, 1'b0, 1'b0);
    chk("adj_to_pause", {st_a, bm_a, bs_a}, {28'd0, 2'd1, 2'b00});
    a_lvl = 1'b1;
    tkn(1, 1'b0, 1'b0);
    tk(1'b0, 1'b1, 1'b0, 1'b0);
    tk(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_in_adj", {min_a, sec_a, bs_a, st_a}, {13'd0, 16'h0000, 1'b0, 2'd2});

    s_lvl = 1'b0;
    tkn(59, 1'b0, 1'b1);
    s_lvl = 1'b1;
    tkn(59, 1'b0, 1'b1);
    chk("preload_5959", {min_a, sec_a}, 32'h5959);
    a_lvl = 1'b0;
    tkn(1, 1'b0, 1'b0);
    tk(1'b0, 1'b0, 1'b1, 1'b0);
    tk(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_59", {min_a, sec_a, min_b, sec_b}, 32'h0000_6000);

    a_lvl = 1'b1; s_lvl = 1'b0;
    tkn(1, 1'b0, 1'b0);
    tkn(39, 1'b0, 1'b1);
    s_lvl = 1'b1;
    tkn(59, 1'b0, 1'b1);
    chk("preload_9959", {min_b, sec_b}, 32'h9959);
    a_lvl = 1'b0;
    tkn(1, 1'b0, 1'b0);
    tk(1'b0, 1'b0, 1'b1, 1'b0);
    tk(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_99", {min_b, sec_b, min_a, sec_a}, 32'h0000_4000);

    for (int i = 0; i < 10000; i++) begin
      logic r, t1, t2, p, c;
      if ($urandom_range(63) == 0) a_lvl = ~a_lvl;
      if ($urandom_range(15) == 0) s_lvl = 1'($urandom_range(1));
      r  = ($urandom_range(499) != 0);
      t1 = ($urandom_range(3) == 0);
      t2 = ($urandom_range(3) == 0);
      p  = ($urandom_range(15) == 0);
      c  = ($urandom_range(127) == 0);
      cyc(r, t1, t2, p, c, a_lvl, s_lvl);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Mode controller and time base for the stopwatch display path. Holds the running minutes:seconds value as packed BCD and sequences it between run, pause and adjust modes using single-cycle tick enables from the clock divider. Drives the `minutes`/`seconds` buses and per-field blank masks consumed by the 7-segment display block. Sits between the divider and the display in the top level, in the `clk` domain.

## Interface
- `MAX_MIN`, default 59: minutes wrap value, decimal 1..99; minutes go from MAX_MIN to 00.
- `clk` in 1: system clock, sole clock.
- `rst` in 1: reset is synchronous and active-low.
- `tick_1hz` in 1: one-cycle enable pulse, 1 Hz count rate.
- `tick_2hz` in 1: one-cycle enable pulse, adjust increment and blink rate.
- `pause_pls` in 1: one-cycle debounced pause/resume toggle request.
- `clear_pls` in 1: one-cycle request to zero the time.
- `adj` in 1: level; 1 selects adjust mode.
- `sel` in 1: level; adjust target, 0 = minutes, 1 = seconds.
- `minutes` out 8: BCD {tens[7:4], ones[3:0]}.
- `seconds` out 8: BCD {tens[7:4], ones[3:0]}, range 00..59.
- `blank_min` out 1: 1 means the display blanks the minutes digits.
- `blank_sec` out 1: 1 means the display blanks the seconds digits.
- `state` out 2: current mode (RUN=0, PAUSE=1, ADJUST=2), for debug and LEDs.

## Operation
- States:
  - RUN: counting.
  - PAUSE: holding the value.
  - ADJUST: manual set.
- Transitions, evaluated each edge in this priority order:
  - `adj`=1 → ADJUST from any state.
  - ADJUST with `adj`=0 → PAUSE.
  - RUN with `pause_pls` → PAUSE.
  - PAUSE with `pause_pls` → RUN.
  - Otherwise hold.
  - `pause_pls` is ignored in ADJUST.
- RUN, on `tick_1hz`: seconds +1 in BCD.
  - Ones digit 9 → 0 with carry into tens.
  - Seconds 59 → 00, minutes +1.
  - Minutes MAX_MIN → 00; the value wraps silently.
- PAUSE: ticks ignored, value held.
- ADJUST, on `tick_2hz`:
  - Field chosen by `sel` +1, same BCD rules.
  - No carry between fields.
  - Seconds wrap 59 → 00; minutes wrap MAX_MIN → 00.
- Blink:
  - A phase bit toggles on every `tick_2hz`, but only while in ADJUST.
  - The phase bit is cleared on entering ADJUST.
  - In ADJUST, the selected field's blank output = phase; the other blank output = 0.
  - Outside ADJUST, both blank outputs = 0.
- `clear_pls`: zeros both fields and the phase bit in any state. The state is unchanged.
- Counters hold only legal BCD; neither digit may ever exceed 9.

## Timing
- Reset (`rst`=0 at an edge):
  - State RUN.
  - minutes=8'h00, seconds=8'h00.
  - Phase 0, both blank outputs 0.
  - All other inputs ignored that cycle.
- All outputs are registered. A tick sampled at edge N is visible on the outputs after edge N, so latency is 1 cycle.
- Mode change takes effect at the same edge as the request; the counting decision uses the state before that edge.
- Same-cycle events:
  - `tick_1hz` + `pause_pls` in RUN: the tick is counted and the state becomes PAUSE.
  - `clear_pls` + any tick: clear wins, result 00:00.
  - `adj` rising + `tick_2hz`: the state becomes ADJUST and no increment happens.
  - `tick_1hz` + `tick_2hz` together: each is applied only in its own mode.
- Reset mid-operation overrides everything, including a pending carry.
- Held `pause_pls` (wider than 1 cycle) toggles the state every cycle. Callers must supply one-cycle pulses.

## Structure
- Shared package `stopwatch_pkg`:
  - State encoding constants ST_RUN, ST_PAUSE, ST_ADJ (2 bits).
  - SEC_MAX = 8'h59.
  - BCD digit width = 4.
- Sub-module `bcd2_counter`:
  - Two-digit BCD counter.
  - Parameter: wrap value.
  - Inputs: `inc`, `clr`.
  - Outputs: value[7:0] and a combinational `wrap` (asserted when `inc` and value == max).
  - Instantiated twice, once for seconds and once for minutes. The minutes `inc` = RUN & seconds wrap, or ADJUST & sel=0 & tick.
- Top-level FSM and blink logic live in `stopwatch_ctrl`.

## Test plan
- Reset:
  - Drive `rst`=0 for 2 cycles → 00:00, state=0, both blank outputs 0.
  - Release, issue 61 `tick_1hz` pulses → 01:01 (8'h01/8'h01).
- Wrap: preload 59:59 by adjust, exit, resume, 1 `tick_1hz` → 00:00.
  - With MAX_MIN=99 and 99:59 → 00:00.
  - Digit rollover: 09 → 10 (8'h09 → 8'h10).
- Pause:
  - `pause_pls` in RUN → state=1; 5 ticks leave the value unchanged.
  - Second `pause_pls` → state=0 and counting resumes.
  - Tick and pause in the same cycle → value +1 and state=1.
- Adjust:
  - `adj`=1, `sel`=1, 3 `tick_2hz` pulses from 00:58 → seconds 8'h01, minutes unchanged.
  - `blank_sec` toggles on each `tick_2hz`; `blank_min`=0.
  - `adj`=0 → state=1 and blank outputs 0.
- Clear priority:
  - `clear_pls` coincident with `tick_1hz` at 12:34 in RUN → 00:00, state stays 0.
  - `clear_pls` in ADJUST → phase and blank outputs 0.
- Random soak: 10k cycles of random pulses checked against a reference model.
  - No BCD digit ever exceeds 9.
  - seconds ≤ 8'h59.
  - minutes ≤ MAX_MIN.
